// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding, default width and counter sizing for the serial link blocks
package serial_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  localparam int DEFAULT_DATA_WIDTH = 8;
  function automatic int counter_width(input int w);
    return $clog2(w) + 1;
  endfunction
endpackage

// File: rtl/deserializer.sv
// deserializer: assembles LSB-first serial frames into words on a valid/ack holding register
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   serial_in           : serial data bit, sampled while serial_valid high
//   serial_valid        : frame envelope, DATA_WIDTH cycles per frame
//   data_out/data_valid : last completed word, held until data_ack
//   data_ack            : consumer acknowledge
//   busy                : frame being assembled
//   frame_error         : pulse on truncated or overlong frame
//   overrun             : pulse when an unacknowledged word is overwritten
module deserializer
  import serial_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int COUNTER_SIZE = counter_width(DATA_WIDTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  serial_in,
  input  logic                  serial_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ack,
  output logic                  busy,
  output logic                  frame_error,
  output logic                  overrun
);
  localparam logic [COUNTER_SIZE-1:0] LAST = COUNTER_SIZE'(DATA_WIDTH - 1);
  state_t state;
  logic [DATA_WIDTH-1:0] shift;
  logic [COUNTER_SIZE-1:0] count;
  logic flagged;
  logic [DATA_WIDTH-1:0] next_shift;
  logic commit;
  assign next_shift = {serial_in, shift[DATA_WIDTH-1:1]};
  // the bit being sampled now is the last one of the frame
  assign commit = state == SHIFT && serial_valid && count == LAST;
  assign busy = state == SHIFT;
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      shift       <= '0;
      count       <= '0;
      flagged     <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      overrun     <= commit && data_valid && !data_ack;
      data_valid  <= commit || (data_valid && !data_ack);
      if (commit) data_out <= next_shift;
      case (state)
        IDLE: if (serial_valid) begin
          shift <= next_shift;
          count <= COUNTER_SIZE'(1);
          state <= SHIFT;
        end
        SHIFT: if (!serial_valid) begin
          frame_error <= 1'b1;
          count       <= '0;
          state       <= IDLE;
        end else begin
          shift <= next_shift;
          count <= count + 1'b1;
          if (commit) state <= GAP;
        end
        // flagged limits an overlong envelope to a single error pulse
        GAP: if (!serial_valid) begin
          state   <= IDLE;
          count   <= '0;
          flagged <= 1'b0;
        end else if (!flagged) begin
          frame_error <= 1'b1;
          flagged     <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer: directed and randomized checks of deserializer against an envelope-length model
module tb_deserializer;
  localparam int N = 8;
  logic clock = 1'b0;
  logic reset, serial_in, serial_valid, data_ack;
  logic [N-1:0] data_out;
  logic data_valid, busy, frame_error, overrun;
  int vectors = 0;
  int miscompares = 0;
  int run = 0;
  logic [N-1:0] word = '0;
  logic [N-1:0] exp_out = '0;
  logic exp_valid = 1'b0, exp_busy = 1'b0, exp_ferr = 1'b0, exp_ovr = 1'b0;

  deserializer #(.DATA_WIDTH(N)) dut (
    .clock(clock), .reset(reset), .serial_in(serial_in), .serial_valid(serial_valid),
    .data_out(data_out), .data_valid(data_valid), .data_ack(data_ack), .busy(busy),
    .frame_error(frame_error), .overrun(overrun)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("data_out", 32'(data_out), 32'(exp_out));
    chk("data_valid", 32'(data_valid), 32'(exp_valid));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("frame_error", 32'(frame_error), 32'(exp_ferr));
    chk("overrun", 32'(overrun), 32'(exp_ovr));
  endtask

  // model: counts consecutive high cycles of the envelope; the Nth completes a word
  task automatic step(input logic sv, input logic b, input logic ack);
    int prev;
    logic commit;
    serial_valid = sv;
    serial_in = b;
    data_ack = ack;
    @(posedge clock);
    prev = run;
    commit = 1'b0;
    exp_ferr = 1'b0;
    if (sv) begin
      if (prev == 0) word = '0;
      run = prev + 1;
      if (run <= N) word[run-1] = b;
      commit = run == N;
      exp_ferr = run == N + 1;
    end else begin
      exp_ferr = prev > 0 && prev < N;
      run = 0;
    end
    exp_ovr = commit && exp_valid && !ack;
    if (commit) begin
      exp_out = word;
      exp_valid = 1'b1;
    end else if (ack) exp_valid = 1'b0;
    exp_busy = run > 0 && run < N;
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    serial_valid = 1'b0;
    serial_in = 1'b0;
    data_ack = 1'b0;
    @(posedge clock);
    run = 0;
    exp_out = '0;
    exp_valid = 1'b0;
    exp_busy = 1'b0;
    exp_ferr = 1'b0;
    exp_ovr = 1'b0;
    #1;
    check_all();
    reset = 1'b0;
  endtask

  // len bits of w (random beyond N); ack driven only on bit ack_bit
  task automatic frame(input logic [N-1:0] w, input int len, input int ack_bit);
    for (int i = 0; i < len; i++)
      step(1'b1, i < N ? w[i] : 1'($urandom), i == ack_bit);
  endtask

  task automatic gap(input int n, input logic ack);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), ack);
  endtask

  initial begin
    reset = 1'b1;
    serial_valid = 1'b0;
    serial_in = 1'b0;
    data_ack = 1'b0;
    repeat (2) @(posedge clock);
    do_reset();
    frame(8'hA5, N, -1);
    gap(1, 1'b0);
    chk("a5_word", 32'(data_out), 32'h0A5);
    gap(1, 1'b1);
    gap(1, 1'b0);
    frame(8'h3C, N, -1);
    gap(1, 1'b1);
    gap(2, 1'b0);
    frame(8'hFF, 5, -1);
    gap(2, 1'b0);
    frame(8'h81, N, -1);
    gap(1, 1'b1);
    frame(8'hF0, N + 2, -1);
    gap(2, 1'b1);
    frame(8'h11, N, -1);
    gap(1, 1'b0);
    frame(8'h22, N, -1);
    gap(1, 1'b0);
    frame(8'h33, N, N - 1);
    gap(1, 1'b1);
    frame(8'h44, N, -1);
    frame(8'h00, 4, -1);
    do_reset();
    frame(8'h5A, N, -1);
    gap(1, 1'b0);
    chk("5a_word", 32'(data_out), 32'h05A);
    for (int k = 0; k < 300; k++) begin
      int len;
      len = ($urandom_range(0, 9) < 7) ? N : int'($urandom_range(1, N + 3));
      frame(N'($urandom), len, ($urandom_range(0, 2) == 0) ? N - 1 : -1);
      for (int g = $urandom_range(1, 3); g > 0; g--) step(1'b0, 1'($urandom), $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 40) == 0) begin
        frame(N'($urandom), $urandom_range(1, N - 1), -1);
        do_reset();
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
Receive-side counterpart of the team's `serializer`. It samples a framed serial bit stream, LSB first, one bit per clock while `serial_valid` is high. It assembles each frame into a DATA_WIDTH-bit word and presents it on a valid/ack holding register. `serial_valid` connects directly to the transmitter's `busy`, and `serial_in` to its `data_out`. The block also flags truncated or overlong frames and words lost to overrun.

Parameters:
DATA_WIDTH, 8, bits per frame/word; must be >= 2.
COUNTER_SIZE, $clog2(DATA_WIDTH)+1, width of the bit counter.

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
serial_in  input  1  serial data bit, LSB first; ignored while serial_valid low
serial_valid  input  1  frame envelope; high for exactly DATA_WIDTH consecutive cycles per frame
data_out  output  DATA_WIDTH  last completed word; stable while data_valid high
data_valid  output  1  word available; held until acknowledged
data_ack  input  1  consumer acknowledge; effective only when data_valid high
busy  output  1  high while a frame is being assembled (state SHIFT)
frame_error  output  1  one-cycle pulse on a truncated or overlong frame
overrun  output  1  one-cycle pulse when a completed word overwrites an unacknowledged one

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clock.
- Reset (any state, including mid-frame):
  - state=IDLE, shift register=0, counter=0, data_out=0.
  - data_valid=0, busy=0, frame_error=0, overrun=0.
  - Any partial frame is discarded.
- States: IDLE, SHIFT, GAP (encoded in the package).
- IDLE:
  - serial_valid=1 -> shift in serial_in, counter=1, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, serial_valid=1:
  - Shift register shifts right; serial_in enters the MSB; counter increments.
  - When the bit just sampled is bit DATA_WIDTH-1 (counter reaches DATA_WIDTH): commit the word and go to GAP.
- SHIFT, serial_valid=0 before DATA_WIDTH bits:
  - frame_error pulses the next cycle; partial word discarded; go to IDLE; data_out and data_valid unchanged.
- GAP:
  - serial_valid=0 -> IDLE.
  - serial_valid=1 (overlong frame) -> frame_error pulse once on entry to the violation, stay in GAP until serial_valid falls; extra bits ignored.
  - A new frame therefore requires at least one low cycle, matching the transmitter's minimum idle gap.
- Commit:
  - data_out <= assembled word (first received bit in bit 0); data_valid <= 1.
  - Latency: if serial_valid is high in cycles T1..TN (N=DATA_WIDTH), data_valid and data_out are valid from cycle TN+1.
- Ack:
  - data_valid=1 and data_ack=1 with no commit -> data_valid=0 next cycle.
  - data_ack while data_valid=0 is ignored.
- Simultaneous commit and ack with data_valid=1: the old word is consumed, the new word loads, data_valid stays 1, no overrun.
- Commit with data_valid=1 and no data_ack: the new word overwrites data_out, data_valid stays 1, overrun pulses for one cycle.
- Flags are pulses, not sticky; frame_error and overrun may assert in the same cycle.
- busy=1 only in SHIFT, so it is high for DATA_WIDTH-1 cycles of a good frame: from T2 through TN.
- serial_in is not interpreted outside SHIFT/IDLE sampling; idle-high line level is not checked.

Decomposition:
- Shared package `serial_pkg`:
  - State enum (IDLE, SHIFT, GAP), shared with the transmitter if it is refactored.
  - Default DATA_WIDTH constant.
  - Counter width function.
- No sub-module. The output holding register with valid/ack/overrun logic is kept inline; at ~40 lines it is not worth separating.

Test Plan:
1. DATA_WIDTH=8, drive serial_valid high 8 cycles with bits 1,0,1,0,0,1,0,1 (0xA5 LSB first) -> data_valid=1 from cycle 9, data_out=0xA5, busy high cycles 2-8, no flags.
2. Loopback: `serializer` data_in=0x3C, start pulse, busy->serial_valid, data_out->serial_in -> data_out=0x3C, data_valid=1; assert data_ack one cycle -> data_valid=0 next cycle.
3. Truncated frame: serial_valid high 5 cycles then low -> frame_error one pulse, data_valid stays 0, state IDLE; the next full frame 0x81 is received correctly.
4. Overlong frame: serial_valid high 10 cycles carrying 0xF0 in the first 8 bits -> data_out=0xF0 and data_valid at cycle 9, one frame_error pulse, no second commit.
5. Overrun: frames 0x11 then 0x22 with a 1-cycle gap, no ack -> overrun pulse at the second commit, data_out=0x22; repeat with data_ack on the commit cycle -> no overrun.
6. Reset mid-frame after 4 bits with data_valid=1 -> all outputs 0 next cycle; the following frame 0x5A is received cleanly.
